// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one AR/R read per instruction, result held for the core until inst_ready.
// Latency 3 cycles IDLE->HOLD at best; arvalid is held until arready, and inst is held until inst_ready.
module ifu_fetch #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [31:0] NOP_INST   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] pc,
    output logic [31:0]           inst,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic                  fetch_err,
    output logic [1:0]            err_cause,
    output logic [31:0]           fetch_cnt,
    output logic [ADDR_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_BUS   = 2'b01;
    localparam logic [1:0] CAUSE_ALIGN = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             inst_q, inst_d;
    logic                    fetch_err_q, fetch_err_d;
    logic [1:0]              err_cause_q, err_cause_d;
    logic [31:0]             fetch_cnt_q, fetch_cnt_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    inst_valid_q, inst_valid_d;

    always_comb begin
        state_d     = state_q;
        inst_d      = inst_q;
        fetch_err_d = fetch_err_q;
        err_cause_d = err_cause_q;
        fetch_cnt_d = fetch_cnt_q;
        araddr_d    = araddr_q;

        case (state_q)
            S_IDLE: begin
                araddr_d = pc;
                // A misaligned pc never reaches the bus; the core gets a NOP tagged with the cause.
                if (pc[1:0] != 2'b00) begin
                    state_d     = S_HOLD;
                    inst_d      = NOP_INST;
                    fetch_err_d = 1'b1;
                    err_cause_d = CAUSE_ALIGN;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (arvalid_q && arready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rready_q && rvalid) begin
                    state_d = S_HOLD;
                    if (rresp == 2'b00) begin
                        inst_d      = rdata;
                        fetch_err_d = 1'b0;
                        err_cause_d = CAUSE_NONE;
                    end else begin
                        inst_d      = NOP_INST;
                        fetch_err_d = 1'b1;
                        err_cause_d = CAUSE_BUS;
                    end
                end
            end
            S_HOLD: begin
                if (inst_valid_q && inst_ready) begin
                    state_d     = S_IDLE;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Handshake outputs are registered copies of the next-state decode.
        arvalid_d    = (state_d == S_REQ);
        rready_d     = (state_d == S_WAIT);
        inst_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            inst_q       <= 32'd0;
            fetch_err_q  <= 1'b0;
            err_cause_q  <= CAUSE_NONE;
            fetch_cnt_q  <= 32'd0;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            inst_q       <= inst_d;
            fetch_err_q  <= fetch_err_d;
            err_cause_q  <= err_cause_d;
            fetch_cnt_q  <= fetch_cnt_d;
            araddr_q     <= araddr_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign fetch_err  = fetch_err_q;
    assign err_cause  = err_cause_q;
    assign fetch_cnt  = fetch_cnt_q;
    assign araddr     = araddr_q;
    assign arvalid    = arvalid_q;
    assign rready     = rready_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table, mid-WAIT reset, then random fetches against a
// transaction-level model of the bus and the core.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = 32'd0;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic        fetch_err;
    logic [1:0]  err_cause;
    logic [31:0] fetch_cnt;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = 32'd0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;

    localparam logic [31:0] NOP = 32'h00000013;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic [31:0] last_inst = 32'd0;

    ifu_fetch #(.ADDR_WIDTH(32), .NOP_INST(NOP)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .fetch_err  (fetch_err),
        .err_cause  (err_cause),
        .fetch_cnt  (fetch_cnt),
        .araddr     (araddr),
        .arvalid    (arvalid),
        .arready    (arready),
        .rdata      (rdata),
        .rresp      (rresp),
        .rvalid     (rvalid),
        .rready     (rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] mem;
        int          ar_lat;
        int          r_lat;
        logic [1:0]  resp;
        int          hold_lat;
        bit          spur;
        logic [31:0] e_inst;
        logic        e_err;
        logic [1:0]  e_cause;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // rst is already 1 here; the next edge resets, and everything is checked just after it.
    task automatic reset_check();
        @(negedge clk);
        exp_cnt   = 32'd0;
        last_inst = 32'd0;
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_inst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_fetch_err", fetch_err, 1'b0);
        chk("rst_err_cause", err_cause, 2'b00);
        chk("rst_fetch_cnt", fetch_cnt, 32'd0);
        chk("rst_araddr", araddr, 32'd0);
    endtask

    // Entered with the DUT about to be in IDLE at the next negedge; returns just before the
    // inst handshake edge (or after raising rst when abort_at >= 0).
    task automatic run_fetch(input logic [31:0] f_pc, input logic [31:0] f_mem,
                             input int ar_lat, input int r_lat, input logic [1:0] resp,
                             input int hold_lat, input bit spur,
                             input logic [31:0] e_inst, input logic e_err, input logic [1:0] e_cause,
                             input int abort_at);
        bit mis;
        bit ar_done = 0;
        bit r_done  = 0;
        int arw = 0;
        int rw  = 0;
        int hw  = 0;
        @(negedge clk);
        rst = 1'b0;
        chk("idle_arvalid", arvalid, 1'b0);
        chk("idle_rready", rready, 1'b0);
        chk("idle_inst_valid", inst_valid, 1'b0);
        chk("idle_inst_kept", inst, last_inst);
        chk("idle_fetch_cnt", fetch_cnt, exp_cnt);
        pc         = f_pc;
        mis        = (f_pc[1:0] != 2'b00);
        arready    = 1'($urandom_range(0, 1));
        rvalid     = 1'b0;
        inst_ready = 1'($urandom_range(0, 1));
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            chk("arvalid", arvalid, !mis && !ar_done);
            if (arvalid) chk("araddr", araddr, f_pc);
            chk("rready", rready, ar_done && !r_done);
            chk("inst_valid", inst_valid, mis || r_done);
            chk("fetch_cnt", fetch_cnt, exp_cnt);
            if (inst_valid) begin
                chk("inst", inst, e_inst);
                chk("fetch_err", fetch_err, e_err);
                chk("err_cause", err_cause, e_cause);
            end
            if (abort_at >= 0 && ar_done && !r_done && rw > abort_at) begin
                rst    = 1'b1;
                rvalid = 1'b0;
                return;
            end
            arready = arvalid ? (arw >= ar_lat) : 1'($urandom_range(0, 1));
            if (arvalid) arw++;
            if (ar_done && !r_done) begin
                rvalid = (rw >= r_lat);
                rdata  = f_mem;
                rresp  = resp;
                rw++;
            end else begin
                // Stray response before the address handshake must be ignored.
                rvalid = spur && arvalid;
                rdata  = 32'hDEADBEEF;
                rresp  = 2'b11;
            end
            inst_ready = inst_valid ? (hw >= hold_lat) : 1'($urandom_range(0, 1));
            if (inst_valid) hw++;
            if (arvalid && arready) ar_done = 1;
            if (rready && rvalid) r_done = 1;
            if (inst_valid && inst_ready) begin
                exp_cnt   = exp_cnt + 32'd1;
                last_inst = e_inst;
                return;
            end
        end
        chk("fetch_timeout", 32'd1, 32'd0);
    endtask

    function automatic void ref_fetch(input logic [31:0] a, input logic [31:0] m, input logic [1:0] r,
                                      output logic [31:0] i, output logic e, output logic [1:0] cs);
        if (a % 4 != 0) begin
            i = NOP; e = 1'b1; cs = 2'b10;
        end else if (r != 2'b00) begin
            i = NOP; e = 1'b1; cs = 2'b01;
        end else begin
            i = m; e = 1'b0; cs = 2'b00;
        end
    endfunction

    initial begin
        vecs[0] = '{32'h80000000, 32'h00100093, 0, 0, 2'b00, 0,  1'b0, 32'h00100093, 1'b0, 2'b00};
        vecs[1] = '{32'h80000004, 32'h00200113, 3, 5, 2'b00, 0,  1'b1, 32'h00200113, 1'b0, 2'b00};
        vecs[2] = '{32'h80000008, 32'h00300193, 0, 0, 2'b00, 10, 1'b0, 32'h00300193, 1'b0, 2'b00};
        vecs[3] = '{32'h80000002, 32'h11111111, 0, 0, 2'b00, 0,  1'b0, NOP,          1'b1, 2'b10};
        vecs[4] = '{32'h8000000C, 32'h12345678, 1, 1, 2'b10, 0,  1'b0, NOP,          1'b1, 2'b01};
        vecs[5] = '{32'h80000010, 32'h00400213, 0, 0, 2'b00, 0,  1'b0, 32'h00400213, 1'b0, 2'b00};
        vecs[6] = '{32'h80000003, 32'h22222222, 0, 0, 2'b00, 3,  1'b0, NOP,          1'b1, 2'b10};
        vecs[7] = '{32'h80000014, 32'hCAFEBABE, 2, 0, 2'b00, 1,  1'b1, 32'hCAFEBABE, 1'b0, 2'b00};

        rst = 1'b1;
        reset_check();

        foreach (vecs[k]) begin
            run_fetch(vecs[k].pc, vecs[k].mem, vecs[k].ar_lat, vecs[k].r_lat, vecs[k].resp,
                      vecs[k].hold_lat, vecs[k].spur, vecs[k].e_inst, vecs[k].e_err,
                      vecs[k].e_cause, -1);
        end

        // Reset while the read is outstanding, then refetch the same pc from scratch.
        run_fetch(32'h80000020, 32'h00500293, 0, 6, 2'b00, 0, 1'b0, 32'h00500293, 1'b0, 2'b00, 2);
        reset_check();
        run_fetch(32'h80000020, 32'h00500293, 0, 0, 2'b00, 0, 1'b0, 32'h00500293, 1'b0, 2'b00, -1);
        run_fetch(32'h80000024, 32'h00600313, 1, 2, 2'b00, 2, 1'b0, 32'h00600313, 1'b0, 2'b00, -1);

        for (int k = 0; k < 60; k++) begin
            logic [31:0] a, m, ei;
            logic [1:0]  r, ec;
            logic        ee;
            a = $urandom;
            if ($urandom_range(0, 5) != 0) a[1:0] = 2'b00;
            m = $urandom;
            r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            ref_fetch(a, m, r, ei, ee, ec);
            run_fetch(a, m, $urandom_range(0, 4), $urandom_range(0, 4), r,
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)), ei, ee, ec, -1);
        end

        @(negedge clk);
        chk("final_fetch_cnt", fetch_cnt, exp_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
